// File: rtl/dmem_pkg.sv
// dmem_pkg: shared defaults, FSM state and address-decode types for dmem_responder
package dmem_pkg;
  localparam int DMEM_DEPTH = 256;
  localparam int DMEM_ADDR_W = $clog2(DMEM_DEPTH);
  localparam logic [31:0] DMEM_MMIO_ADDR = 32'hFFFF_FFF0;
  typedef enum logic {S_CLEAR, S_READY} state_e;
  typedef enum logic [1:0] {D_IN_RANGE, D_MMIO, D_UNMAPPED} dec_e;
  function automatic dec_e decode(input logic [31:0] a, input int aw, input logic [31:0] mmio);
    return (a >> aw) == 32'd0 ? D_IN_RANGE : a == mmio ? D_MMIO : D_UNMAPPED;
  endfunction
endpackage

// File: rtl/dmem_read_pipe.sv
// dmem_read_pipe: READ_LAT-stage 32-bit read-data shift register, synchronous flush on rst
module dmem_read_pipe #(
  parameter int READ_LAT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] i_d,
  output logic [31:0] o_q
);
  logic [31:0] r_st [READ_LAT];
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < READ_LAT; i++) r_st[i] <= '0;
    end else begin
      r_st[0] <= i_d;
      for (int i = 1; i < READ_LAT; i++) r_st[i] <= r_st[i-1];
    end
  end
  assign o_q = r_st[READ_LAT-1];
endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: word-addressed data RAM + IO_OUT register with post-reset clear FSM
// Optional parity storage/check enabled by DMEM_PARITY_EN (adds PAR_ERR port).
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int          DEPTH     = DMEM_DEPTH,
  parameter int          READ_LAT  = 1,
  parameter logic [31:0] MMIO_ADDR = DMEM_MMIO_ADDR
) (
  input  logic        clk,
  input  logic        RST,
  input  logic [31:0] DADDR,
  input  logic [31:0] DATA_OUT,
  input  logic        DWR,
  output logic [31:0] DATA_IN,
  output logic [31:0] IO_OUT,
  output logic        READY,
`ifdef DMEM_PARITY_EN
  output logic        PAR_ERR,
`endif
  output logic        ADDR_ERR
);
  localparam int ADDR_W = $clog2(DEPTH);
  state_e r_state, w_state_nx;
  logic [ADDR_W-1:0] r_ptr, w_idx, w_mem_wa;
  logic [31:0] r_mem [DEPTH];
  logic [31:0] r_io, w_mem_wd, w_rd;
  logic r_ready, r_addr_err, w_act, w_wr, w_mem_we;
  dec_e w_dec;
  assign w_dec    = decode(DADDR, ADDR_W, MMIO_ADDR);
  assign w_idx    = DADDR[ADDR_W-1:0];
  assign w_act    = r_state == S_READY;
  assign w_wr     = w_act && DWR;
  assign w_mem_we = !RST && (r_state == S_CLEAR || (w_wr && w_dec == D_IN_RANGE));
  assign w_mem_wa = w_act ? w_idx : r_ptr;
  assign w_mem_wd = w_act ? DATA_OUT : '0;
  // Write-first: a same-edge write to a mapped address is what the read sees
  assign w_rd = !w_act ? '0
              : (w_wr && w_dec != D_UNMAPPED) ? DATA_OUT
              : w_dec == D_IN_RANGE ? r_mem[w_idx]
              : w_dec == D_MMIO ? r_io : '0;
  always_comb begin
    w_state_nx = r_state;
    w_state_nx = (r_state == S_CLEAR && r_ptr == ADDR_W'(DEPTH-1)) ? S_READY : r_state;
  end
  always_ff @(posedge clk) begin
    if (RST) begin
      r_state    <= S_CLEAR;
      r_ptr      <= '0;
      r_io       <= '0;
      r_ready    <= 1'b0;
      r_addr_err <= 1'b0;
    end else begin
      r_state    <= w_state_nx;
      r_ptr      <= r_state == S_CLEAR ? r_ptr + 1'b1 : r_ptr;
      r_ready    <= w_act;
      r_io       <= (w_wr && w_dec == D_MMIO) ? DATA_OUT : r_io;
      r_addr_err <= r_addr_err | (w_wr && w_dec == D_UNMAPPED);
    end
  end
  always_ff @(posedge clk) if (w_mem_we) r_mem[w_mem_wa] <= w_mem_wd;
`ifdef DMEM_PARITY_EN
  logic r_par [DEPTH];
  logic r_par_err, w_par_bad;
  assign w_par_bad = w_act && w_dec == D_IN_RANGE && !DWR && ((^r_mem[w_idx]) != r_par[w_idx]);
  always_ff @(posedge clk) if (w_mem_we) r_par[w_mem_wa] <= ^w_mem_wd;
  always_ff @(posedge clk) r_par_err <= RST ? 1'b0 : (r_par_err | w_par_bad);
  assign PAR_ERR = r_par_err;
`endif
  dmem_read_pipe #(.READ_LAT(READ_LAT)) u_pipe (
    .clk(clk),
    .rst(RST),
    .i_d(w_rd),
    .o_q(DATA_IN)
  );
  assign IO_OUT   = r_io;
  assign READY    = r_ready;
  assign ADDR_ERR = r_addr_err;
endmodule
